// File: rtl/axi4_burst_mem_if.sv
// AXI4 burst memory bus bundle: AW, W, B, AR and R channel signals.
// slave modport: the memory side (axi4_burst_mem); master modport: the initiator side.
// Clock and reset are not part of the bundle; they stay plain ports on the design.
interface axi4_burst_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi4_burst_mem.sv
// AXI4 burst-capable memory slave with independent, concurrent read and write channels.
// Ports:
//   ACLK   - clock, rising edge
//   ARESET - asynchronous active-high reset (memory contents are kept)
//   bus    - axi4_burst_mem_if.slave: AW/W/B write channels, AR/R read channels
// Supports FIXED/INCR/WRAP bursts; illegal bursts and out-of-range words answer SLVERR.
module axi4_burst_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input logic             ACLK,
  input logic             ARESET,
  axi4_burst_mem_if.slave bus
);
  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = $clog2(MEMORY_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01,
                            BURST_WRAP  = 2'b10, BURST_RSVD = 2'b11} burst_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] bt);
    logic [31:0] last_off;
    // Offset of the last byte within the 4 KiB page; INCR must not cross it.
    last_off = (32'(addr) & 32'h0000_0FFF) + ((32'(len) + 32'd1) << size) - 32'd1;
    burst_err = (size > 3'(BYTE_SHIFT)) || (bt == BURST_RSVD) ||
                (bt == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
                (bt == BURST_INCR && last_off > 32'h0000_0FFF);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [ADDR_WIDTH-1:0] start, input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] bt);
    logic [ADDR_WIDTH-1:0] step, wmask;
    step  = ADDR_WIDTH'(32'd1 << size);
    wmask = ADDR_WIDTH'(((32'(len) + 32'd1) << size) - 32'd1);
    case (bt)
      BURST_INCR: next_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
      BURST_WRAP: next_addr = (start & ~wmask) | ((addr + step) & wmask);
      default:    next_addr = addr;
    endcase
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    in_range = (32'(addr) >> BYTE_SHIFT) < 32'(MEMORY_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    word_idx = IDX_W'(addr >> BYTE_SHIFT);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // ---------------- write channel ----------------
  w_state_t              w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr, w_start;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [8:0]            w_rem;
  logic                  w_err, w_oor;
  logic                  aw_fire, aw_err, w_fire, w_in_range, mem_we;

  always_comb begin
    aw_fire    = (w_state == W_IDLE) && bus.AWVALID;
    aw_err     = burst_err(bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST);
    w_fire     = (w_state == W_DATA) && bus.WVALID;
    w_in_range = in_range(w_addr);
    mem_we     = w_fire && !w_err && w_in_range;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (bus.AWVALID) w_state_nxt = W_DATA;
      W_DATA:  if (bus.WVALID && w_rem == 9'd1) w_state_nxt = W_RESP;
      W_RESP:  if (bus.BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    bus.AWREADY = (w_state == W_IDLE);
    bus.WREADY  = (w_state == W_DATA);
    bus.BVALID  = (w_state == W_RESP);
    bus.BRESP   = (w_state == W_RESP && (w_err || w_oor)) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_addr  <= '0;
      w_start <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_rem   <= '0;
      w_err   <= 1'b0;
      w_oor   <= 1'b0;
    end else if (aw_fire) begin
      w_addr  <= bus.AWADDR;
      w_start <= bus.AWADDR;
      w_len   <= bus.AWLEN;
      w_size  <= bus.AWSIZE;
      w_burst <= bus.AWBURST;
      w_rem   <= {1'b0, bus.AWLEN} + 9'd1;
      w_err   <= aw_err;
      w_oor   <= 1'b0;
    end else if (w_fire) begin
      w_addr <= next_addr(w_addr, w_start, w_len, w_size, w_burst);
      w_rem  <= w_rem - 9'd1;
      if (!w_in_range) w_oor <= 1'b1;
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_start, r_next, rd_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [8:0]            r_rem;
  logic                  r_err, r_beat_err;
  logic                  ar_fire, ar_err, r_adv, mem_re, rd_err;

  // The first read is issued straight from ARADDR on the handshake edge; later
  // reads are issued on each non-final R handshake so beats stream back to back.
  always_comb begin
    ar_fire = (r_state == R_IDLE) && bus.ARVALID;
    ar_err  = burst_err(bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST);
    r_next  = next_addr(r_addr, r_start, r_len, r_size, r_burst);
    r_adv   = (r_state == R_DATA) && bus.RREADY && (r_rem != 9'd1);
    mem_re  = ar_fire || r_adv;
    rd_addr = ar_fire ? bus.ARADDR : r_next;
    rd_err  = ar_fire ? ar_err : r_err;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (bus.ARVALID) r_state_nxt = R_FETCH;
      R_FETCH: r_state_nxt = R_DATA;
      R_DATA:  if (bus.RREADY && r_rem == 9'd1) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    bus.ARREADY = (r_state == R_IDLE);
    bus.RVALID  = (r_state == R_DATA);
    bus.RLAST   = (r_state == R_DATA) && (r_rem == 9'd1);
    bus.RRESP   = (r_state == R_DATA && r_beat_err) ? RESP_SLVERR : RESP_OKAY;
    bus.RDATA   = (r_state == R_DATA && !r_beat_err) ? rd_word : '0;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_addr     <= '0;
      r_start    <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_beat_err <= 1'b0;
    end else begin
      if (ar_fire) begin
        r_addr  <= bus.ARADDR;
        r_start <= bus.ARADDR;
        r_len   <= bus.ARLEN;
        r_size  <= bus.ARSIZE;
        r_burst <= bus.ARBURST;
        r_rem   <= {1'b0, bus.ARLEN} + 9'd1;
        r_err   <= ar_err;
      end else if (r_adv) begin
        r_addr <= r_next;
        r_rem  <= r_rem - 9'd1;
      end
      if (mem_re) r_beat_err <= rd_err || !in_range(rd_addr);
    end
  end

  // Storage: no reset. Non-blocking read of the same word written this cycle
  // returns the pre-write contents.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (bus.WSTRB[i]) mem[word_idx(w_addr)][8*i +: 8] <= bus.WDATA[8*i +: 8];
      end
    end
    if (mem_re) rd_word <= mem[word_idx(rd_addr)];
  end
endmodule

// File: tb/tb_axi4_burst_mem.sv
module tb_axi4_burst_mem;
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi4_burst_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axi4_burst_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  typedef struct packed {logic [31:0] d; logic [1:0] r; logic l;} rbeat_t;

  int total = 0;
  int bad   = 0;
  rbeat_t     rq[$];
  logic [1:0] bq[$];
  logic [31:0] wd[16];
  logic [3:0]  ws[16];
  logic [31:0] rx[16];
  logic [1:0]  rr[16];
  rbeat_t held;
  bit     held_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, 64'({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID,
                   bus.RLAST, bus.BRESP, bus.RRESP}), 64'(10'b11_0000_0000));
    chk({name, "_rdata"}, 64'(bus.RDATA), 64'(0));
  endtask

  // Scoreboard monitor: compares every B and R handshake against the queues.
  always @(negedge ACLK) begin
    if (ARESET) held_v = 1'b0;
    else begin
      if (bus.BVALID && bus.BREADY) begin
        if (bq.size() == 0) note("b_unexpected");
        else chk("bresp", 64'(bus.BRESP), 64'(bq.pop_front()));
      end
      if (bus.RVALID) begin
        if (held_v) chk("r_hold", 64'({bus.RDATA, bus.RRESP, bus.RLAST}), 64'(held));
        if (bus.RREADY) begin
          if (rq.size() == 0) note("r_unexpected");
          else begin
            held = rq.pop_front();
            chk("rdata", 64'(bus.RDATA), 64'(held.d));
            chk("rresp", 64'(bus.RRESP), 64'(held.r));
            chk("rlast", 64'(bus.RLAST), 64'(held.l));
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = '{d: bus.RDATA, r: bus.RRESP, l: bus.RLAST};
        end
      end else held_v = 1'b0;
    end
  end

  task automatic w_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input logic [1:0] exp, input int bdelay,
                         input int abort_at);
    int n;
    if (abort_at < 0) bq.push_back(exp);
    @(posedge ACLK); #1;
    bus.AWADDR = a; bus.AWLEN = len; bus.AWSIZE = sz; bus.AWBURST = bt; bus.AWVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!bus.AWREADY && n < 50);
    if (!bus.AWREADY) begin note("aw_timeout"); bus.AWVALID = 1'b0; bq.delete(); return; end
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.WDATA = wd[i]; bus.WSTRB = ws[i]; bus.WVALID = 1'b1;
      if (i == abort_at) begin
        #2 ARESET = 1'b1;
        #1 chk_reset_outs("abort_reset");
        bus.WVALID = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        return;
      end
      n = 0;
      do begin @(negedge ACLK); n++; end while (!bus.WREADY && n < 50);
      if (!bus.WREADY) begin note("w_timeout"); bus.WVALID = 1'b0; bq.delete(); return; end
      @(posedge ACLK); #1;
    end
    bus.WVALID = 1'b0;
    for (int k = 0; k < bdelay; k++) begin
      @(negedge ACLK);
      chk("b_stall_valid", 64'(bus.BVALID), 64'(1));
      chk("b_stall_resp", 64'(bus.BRESP), 64'(exp));
      @(posedge ACLK); #1;
    end
    bus.BREADY = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!bus.BVALID && n < 50);
    if (!bus.BVALID) begin note("b_timeout"); bq.delete(); end
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    chk("awready_back", 64'(bus.AWREADY), 64'(1));
  endtask

  task automatic r_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input bit tog);
    int n, cnt;
    for (int i = 0; i <= int'(len); i++) rq.push_back('{d: rx[i], r: rr[i], l: (i == int'(len))});
    @(posedge ACLK); #1;
    bus.ARADDR = a; bus.ARLEN = len; bus.ARSIZE = sz; bus.ARBURST = bt; bus.ARVALID = 1'b1;
    bus.RREADY = !tog;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!bus.ARREADY && n < 50);
    if (!bus.ARREADY) begin note("ar_timeout"); bus.ARVALID = 1'b0; rq.delete(); return; end
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    @(negedge ACLK);
    chk("r_fetch_rvalid", 64'(bus.RVALID), 64'(0));
    @(negedge ACLK);
    chk("r_first_rvalid", 64'(bus.RVALID), 64'(1));
    cnt = bus.RVALID ? 1 : 0;
    n = 0;
    while (rq.size() != 0 && n < 100) begin
      @(posedge ACLK); #1;
      if (tog) bus.RREADY = !bus.RREADY;
      @(negedge ACLK);
      n++;
      if (bus.RVALID) cnt++;
    end
    if (rq.size() != 0) begin note("r_timeout"); rq.delete(); end
    else if (!tog) chk("r_consec", 64'(cnt), 64'(int'(len) + 1));
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
    @(negedge ACLK);
    chk("arready_back", 64'(bus.ARREADY), 64'(1));
  endtask

  task automatic set_w(input int i, input logic [31:0] d, input logic [3:0] s);
    wd[i] = d; ws[i] = s;
  endtask

  task automatic set_r(input int i, input logic [31:0] d, input logic [1:0] r);
    rx[i] = d; rr[i] = r;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    #3 chk_reset_outs("reset");
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // INCR write words 4..7, read back streaming
    for (int i = 0; i < 4; i++) set_w(i, 32'hA0 + i, 4'hF);
    w_burst(16'h0010, 8'd3, 3'd2, INCR, OKAY, 0, -1);
    for (int i = 0; i < 4; i++) set_r(i, 32'hA0 + i, OKAY);
    r_burst(16'h0010, 8'd3, 3'd2, INCR, 1'b0);

    // WRAP read 0x38 -> 0x38,0x3C,0x30,0x34 with RREADY toggling
    for (int i = 0; i < 4; i++) set_w(i, 32'hC0 + i, 4'hF);
    w_burst(16'h0030, 8'd3, 3'd2, INCR, OKAY, 0, -1);
    set_r(0, 32'hC2, OKAY); set_r(1, 32'hC3, OKAY); set_r(2, 32'hC0, OKAY); set_r(3, 32'hC1, OKAY);
    r_burst(16'h0038, 8'd3, 3'd2, WRAP, 1'b1);

    // 4 KiB crossing write is rejected and leaves memory untouched
    set_w(0, 32'h1111_1111, 4'hF); set_w(1, 32'h2222_2222, 4'hF);
    w_burst(16'h0FF8, 8'd1, 3'd2, INCR, OKAY, 0, -1);
    for (int i = 0; i < 4; i++) set_w(i, 32'hDEAD_0000 + i, 4'hF);
    w_burst(16'h0FF8, 8'd3, 3'd2, INCR, SLVERR, 0, -1);
    set_r(0, 32'h1111_1111, OKAY); set_r(1, 32'h2222_2222, OKAY);
    r_burst(16'h0FF8, 8'd1, 3'd2, INCR, 1'b0);

    // Out-of-range word and illegal WRAP length
    set_r(0, 32'h0, SLVERR);
    r_burst(16'h1000, 8'd0, 3'd2, INCR, 1'b0);
    set_w(0, 32'h5A5A_5A5A, 4'hF);
    w_burst(16'h1000, 8'd0, 3'd2, INCR, SLVERR, 0, -1);
    for (int i = 0; i < 3; i++) set_r(i, 32'h0, SLVERR);
    r_burst(16'h0010, 8'd2, 3'd2, WRAP, 1'b0);

    // Byte strobes, with a 5-cycle BREADY stall
    set_w(0, 32'h1122_3344, 4'hF); set_w(1, 32'h1122_3344, 4'hF);
    w_burst(16'h0040, 8'd1, 3'd2, INCR, OKAY, 0, -1);
    set_w(0, 32'hAABB_CCDD, 4'b0101); set_w(1, 32'hAABB_CCDD, 4'b0100);
    w_burst(16'h0040, 8'd1, 3'd2, INCR, OKAY, 5, -1);
    set_r(0, 32'h11BB_33DD, OKAY); set_r(1, 32'h11BB_3344, OKAY);
    r_burst(16'h0040, 8'd1, 3'd2, INCR, 1'b0);

    // FIXED burst keeps hitting the same word
    set_w(0, 32'h1, 4'hF); set_w(1, 32'h2, 4'hF); set_w(2, 32'h3, 4'hF);
    w_burst(16'h0080, 8'd2, 3'd2, FIXED, OKAY, 0, -1);
    set_r(0, 32'h3, OKAY); set_r(1, 32'h3, OKAY);
    r_burst(16'h0080, 8'd1, 3'd2, FIXED, 1'b0);

    // Reset during beat 2 of a LEN=7 write: only words 0,1 change
    for (int i = 0; i < 8; i++) set_w(i, 32'h50 + i, 4'hF);
    w_burst(16'h0000, 8'd7, 3'd2, INCR, OKAY, 0, -1);
    for (int i = 0; i < 8; i++) set_w(i, 32'h60 + i, 4'hF);
    w_burst(16'h0000, 8'd7, 3'd2, INCR, OKAY, 0, 2);
    set_r(0, 32'h60, OKAY); set_r(1, 32'h61, OKAY);
    for (int i = 2; i < 8; i++) set_r(i, 32'h50 + i, OKAY);
    r_burst(16'h0000, 8'd7, 3'd2, INCR, 1'b0);

    repeat (3) @(posedge ACLK);
    if (bq.size() != 0 || rq.size() != 0) note("leftover_expectations");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
